// File: rtl/compare_scoreboard_if.sv
// Handshake bundle between the compare bench and compare_scoreboard.
// COMPARE_SB_LANE_CNT_EN adds the per-lane fail counter vector.
interface compare_scoreboard_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             sample_valid;
  logic [LANES-1:0] ok;
  logic             busy;
  logic             done;
  logic             fail;
  logic             halt;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic [LANES-1:0] first_fail_mask;
`ifdef COMPARE_SB_LANE_CNT_EN
  logic [LANES*CNT_W-1:0] lane_fail_cnt;
`endif

  modport master (
    output start, sample_valid, ok,
    input  busy, done, fail, halt, sample_cnt, fail_cnt, first_fail_idx, first_fail_mask
`ifdef COMPARE_SB_LANE_CNT_EN
    , input lane_fail_cnt
`endif
  );

  modport slave (
    input  start, sample_valid, ok,
    output busy, done, fail, halt, sample_cnt, fail_cnt, first_fail_idx, first_fail_mask
`ifdef COMPARE_SB_LANE_CNT_EN
    , output lane_fail_cnt
`endif
  );
endinterface

// File: rtl/compare_scoreboard.sv
// Scoreboard for per-lane ok bits: warm-up skip, sample/fail counting, first-failure capture, halt.
// COMPARE_SB_LANE_CNT_EN adds one saturating fail counter per lane.
module compare_scoreboard #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_FAIL = 1,
  parameter int unsigned WARMUP   = 2
) (
  input logic                clk,
  input logic                reset,
  compare_scoreboard_if.slave sb
);

  localparam int unsigned    WarmW     = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WarmW-1:0] WarmLast = WarmW'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [CNT_W-1:0] FailLimit = CNT_W'(MAX_FAIL);

  typedef enum logic [1:0] {StIdle, StWarm, StRun, StStop} state_e;

  state_e           state_q;
  logic [WarmW-1:0] warm_cnt_q;
  logic             busy_q, done_q, fail_q, halt_q;
  logic [CNT_W-1:0] sample_cnt_q, fail_cnt_q, first_fail_idx_q;
  logic [LANES-1:0] first_fail_mask_q;
`ifdef COMPARE_SB_LANE_CNT_EN
  logic [LANES*CNT_W-1:0] lane_cnt_q;
`endif

  logic [LANES-1:0] bad;
  logic             any_bad;
  logic [CNT_W-1:0] sample_inc, fail_inc;

  // Case equality so X/Z on a lane counts as a mismatch in simulation.
  always_comb begin
    bad = '0;
    for (int i = 0; i < LANES; i++) begin
      bad[i] = (sb.ok[i] !== 1'b1);
    end
    any_bad    = |bad;
    sample_inc = (sample_cnt_q == '1) ? sample_cnt_q : sample_cnt_q + CNT_W'(1);
    fail_inc   = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= StIdle;
      warm_cnt_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      fail_q            <= 1'b0;
      halt_q            <= 1'b0;
      sample_cnt_q      <= '0;
      fail_cnt_q        <= '0;
      first_fail_idx_q  <= '0;
      first_fail_mask_q <= '0;
`ifdef COMPARE_SB_LANE_CNT_EN
      lane_cnt_q        <= '0;
`endif
    end else begin
      halt_q <= 1'b0;
      case (state_q)
        StIdle, StStop: begin
          if (sb.start) begin
            warm_cnt_q        <= '0;
            fail_q            <= 1'b0;
            sample_cnt_q      <= '0;
            fail_cnt_q        <= '0;
            first_fail_idx_q  <= '0;
            first_fail_mask_q <= '0;
`ifdef COMPARE_SB_LANE_CNT_EN
            lane_cnt_q        <= '0;
`endif
            busy_q            <= 1'b1;
            done_q            <= 1'b0;
            state_q           <= (WARMUP == 0) ? StRun : StWarm;
          end
        end
        StWarm: begin
          if (sb.sample_valid) begin
            if (warm_cnt_q == WarmLast) begin
              state_q <= StRun;
            end else begin
              warm_cnt_q <= warm_cnt_q + WarmW'(1);
            end
          end
        end
        StRun: begin
          if (sb.sample_valid) begin
            sample_cnt_q <= sample_inc;
            if (any_bad) begin
              fail_cnt_q <= fail_inc;
              fail_q     <= 1'b1;
              if (!fail_q) begin
                first_fail_idx_q  <= sample_cnt_q;
                first_fail_mask_q <= bad;
              end
              // Compare the post-increment (possibly saturated) count against the budget.
              if ((MAX_FAIL != 0) && (fail_inc == FailLimit)) begin
                state_q <= StStop;
                halt_q  <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
`ifdef COMPARE_SB_LANE_CNT_EN
            for (int i = 0; i < LANES; i++) begin
              if (bad[i] && (lane_cnt_q[i*CNT_W +: CNT_W] != '1)) begin
                lane_cnt_q[i*CNT_W +: CNT_W] <= lane_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
              end
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sb.busy            = busy_q;
  assign sb.done            = done_q;
  assign sb.fail            = fail_q;
  assign sb.halt            = halt_q;
  assign sb.sample_cnt      = sample_cnt_q;
  assign sb.fail_cnt        = fail_cnt_q;
  assign sb.first_fail_idx  = first_fail_idx_q;
  assign sb.first_fail_mask = first_fail_mask_q;
`ifdef COMPARE_SB_LANE_CNT_EN
  assign sb.lane_fail_cnt   = lane_cnt_q;
`endif

endmodule

// File: tb/tb_compare_scoreboard.sv
// Directed bench for compare_scoreboard: dut_a uses MAX_FAIL=1/CNT_W=16, dut_b MAX_FAIL=0/CNT_W=4.
module tb_compare_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  compare_scoreboard_if #(.LANES(4), .CNT_W(16)) sb_a ();
  compare_scoreboard_if #(.LANES(4), .CNT_W(4))  sb_b ();

  compare_scoreboard #(.LANES(4), .CNT_W(16), .MAX_FAIL(1), .WARMUP(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_a)
  );

  compare_scoreboard #(.LANES(4), .CNT_W(4), .MAX_FAIL(0), .WARMUP(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs on the selected DUT; inputs drop back to idle afterwards.
  task automatic drive(input bit to_b, input bit st, input bit vld, input logic [3:0] okv);
    if (to_b) begin
      sb_b.start = st; sb_b.sample_valid = vld; sb_b.ok = okv;
    end else begin
      sb_a.start = st; sb_a.sample_valid = vld; sb_a.ok = okv;
    end
    @(posedge clk);
    #1;
    sb_a.start = 1'b0; sb_a.sample_valid = 1'b0; sb_a.ok = 4'hF;
    sb_b.start = 1'b0; sb_b.sample_valid = 1'b0; sb_b.ok = 4'hF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    sb_a.start = 1'b0; sb_a.sample_valid = 1'b0; sb_a.ok = 4'hF;
    sb_b.start = 1'b0; sb_b.sample_valid = 1'b0; sb_b.ok = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(sb_a.busy), 64'd0);
    check("rst_done", 64'(sb_a.done), 64'd0);
    check("rst_flags", 64'({sb_a.fail, sb_a.halt}), 64'd0);
    check("rst_cnts", 64'({sb_a.sample_cnt, sb_a.fail_cnt, sb_a.first_fail_idx}), 64'd0);
    check("rst_mask", 64'(sb_a.first_fail_mask), 64'd0);
    reset = 1'b0;

    // All-good run: 2 warm-up samples ignored, 8 counted.
    drive(0, 1, 0, 4'hF);
    check("t1_busy_warm", 64'(sb_a.busy), 64'd1);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 4'hF);
    check("t1_sample_cnt", 64'(sb_a.sample_cnt), 64'd8);
    check("t1_fail", 64'(sb_a.fail), 64'd0);
    check("t1_done", 64'(sb_a.done), 64'd0);
    check("t1_fail_cnt", 64'(sb_a.fail_cnt), 64'd0);
    drive(0, 1, 0, 4'hF);
    drive(0, 0, 0, 4'h0);
    check("t1_start_in_run", 64'(sb_a.sample_cnt), 64'd8);
    check("t1_invalid_ignored", 64'(sb_a.fail), 64'd0);

    // Bad lanes during warm-up are not counted.
    do_reset();
    drive(0, 1, 0, 4'hF);
    drive(0, 0, 1, 4'bxxxx);
    drive(0, 0, 1, 4'bxxxx);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 4'hF);
    check("t2_fail", 64'(sb_a.fail), 64'd0);
    check("t2_sample_cnt", 64'(sb_a.sample_cnt), 64'd3);

    // First failure on the 3rd RUN sample stops the MAX_FAIL=1 instance.
    do_reset();
    drive(0, 1, 0, 4'hF);
    drive(0, 0, 1, 4'hF);
    drive(0, 0, 1, 4'hF);
    drive(0, 0, 1, 4'hF);
    drive(0, 0, 1, 4'hF);
    drive(0, 0, 1, 4'b1011);
    check("t3_idx", 64'(sb_a.first_fail_idx), 64'd2);
    check("t3_mask", 64'(sb_a.first_fail_mask), 64'b0100);
    check("t3_halt", 64'(sb_a.halt), 64'd1);
    check("t3_done_busy", 64'({sb_a.done, sb_a.busy}), 64'b10);
    check("t3_counts", 64'({sb_a.sample_cnt, sb_a.fail_cnt}), {32'd0, 16'd3, 16'd1});
    drive(0, 0, 1, 4'h0);
    check("t3_halt_once", 64'(sb_a.halt), 64'd0);
    drive(0, 0, 1, 4'h0);
    check("t3_stop_hold", 64'({sb_a.sample_cnt, sb_a.fail_cnt}), {32'd0, 16'd3, 16'd1});
    check("t3_stop_mask", 64'(sb_a.first_fail_mask), 64'b0100);
    check("t3_done_hold", 64'(sb_a.done), 64'd1);
    // Restart from STOP clears everything.
    drive(0, 1, 0, 4'hF);
    check("t3_restart_flags", 64'({sb_a.busy, sb_a.done, sb_a.fail}), 64'b100);
    check("t3_restart_cnts", 64'({sb_a.sample_cnt, sb_a.fail_cnt, sb_a.first_fail_mask}), 64'd0);

    // Saturation without stopping on the 4-bit, MAX_FAIL=0 instance.
    do_reset();
    drive(1, 1, 0, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'hF);
    for (int i = 0; i < 20; i++) drive(1, 0, 1, 4'h0);
    check("t4_sample_sat", 64'(sb_b.sample_cnt), 64'hF);
    check("t4_fail_sat", 64'(sb_b.fail_cnt), 64'hF);
    check("t4_no_stop", 64'({sb_b.busy, sb_b.done}), 64'b10);
    check("t4_first", 64'({sb_b.first_fail_idx, sb_b.first_fail_mask}), 64'h0F);

    // Asynchronous reset in the middle of a run, then a clean rerun.
    do_reset();
    drive(1, 1, 0, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'b1110);
    check("t5_pre_fail", 64'({sb_b.fail, sb_b.sample_cnt}), 64'h11);
    reset = 1'b1;
    #1;
    check("t5_async_clr", 64'({sb_b.busy, sb_b.done, sb_b.fail, sb_b.halt}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_cnts_clr", 64'({sb_b.sample_cnt, sb_b.fail_cnt, sb_b.first_fail_idx,
                             sb_b.first_fail_mask}), 64'd0);
    drive(1, 1, 0, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'hF);
    check("t5_rerun", 64'({sb_b.fail, sb_b.sample_cnt, sb_b.fail_cnt}), 64'h020);

`ifdef COMPARE_SB_LANE_CNT_EN
    do_reset();
    drive(1, 1, 0, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'hF);
    drive(1, 0, 1, 4'b1101);
    drive(1, 0, 1, 4'b0101);
    drive(1, 0, 1, 4'b1111);
    check("t6_lane_cnt", 64'(sb_b.lane_fail_cnt), 64'h1020);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
